serial_channel_arbiter: RTL and testbench

//   Shares the single serial data channel (SDRD line) between two bus-side requesters.
//   Per transaction: arbitrate round-robin, capture one data word, then sequence

---
 rtl/serial_channel_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_serial_channel_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_channel_arbiter.sv
// Two-requester round-robin arbiter in front of the SDRD serial line.
// Each grant captures one data word and sends it as a frame:
// start bit, DATA_W data bits (LSB first), optional parity bit, stop bit.
// Every bit lasts BIT_CYCLES clocks. The owner gets a one-cycle done pulse.
module serial_channel_arbiter #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [2*DATA_W-1:0]   req_data,
    output logic [1:0]            req_ready,
    output logic [1:0]            gnt,
    output logic                  sdrd,
    output logic                  sd_oe,
    output logic [1:0]            done,
    output logic                  busy
);

    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(DATA_W - 1);
    localparam logic             ParEn   = (PARITY_EN != 0);
    localparam logic             ParOdd  = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    // Requester favoured when both are valid.
    logic                prio_q, prio_d;
    logic                sdrd_q, sdrd_d;
    logic                sd_oe_q, sd_oe_d;

    logic                win_valid;
    logic                win_sel;
    logic                grant_now;
    logic                bit_wrap;

    // Pick a winner among the valid requesters using the round-robin pointer.
    always_comb begin
        win_valid = 1'b0;
        win_sel   = 1'b0;
        case (req_valid)
            2'b01: begin
                win_valid = 1'b1;
                win_sel   = 1'b0;
            end
            2'b10: begin
                win_valid = 1'b1;
                win_sel   = 1'b1;
            end
            2'b11: begin
                win_valid = 1'b1;
                win_sel   = prio_q;
            end
            default: begin
                win_valid = 1'b0;
                win_sel   = 1'b0;
            end
        endcase
    end

    assign grant_now = (state_q == StIdle) && win_valid;
    assign req_ready = {win_sel, ~win_sel} & {2{grant_now}};
    assign bit_wrap  = (cnt_q == CntLast);

    // Frame sequencer: next state, bit timing, capture and line value for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        prio_d  = prio_q;
        sdrd_d  = 1'b1;
        sd_oe_d = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = bit_wrap ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (grant_now) begin
                    data_d  = win_sel ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
                    gnt_d   = {win_sel, ~win_sel};
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_wrap) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_wrap) begin
                    if (idx_q == IdxLast) begin
                        state_d = ParEn ? StParity : StStop;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StParity: begin
                if (bit_wrap) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_wrap) begin
                    state_d = StIdle;
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    // Owner 0 hands priority to 1 and vice versa.
                    prio_d  = gnt_q[0];
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
        endcase

        // Register the line from the next state so sdrd changes only on clock edges.
        case (state_d)
            StStart:  sdrd_d = 1'b0;
            StData:   sdrd_d = data_d[idx_d];
            StParity: sdrd_d = (^data_q) ^ ParOdd;
            default:  sdrd_d = 1'b1;
        endcase
        sd_oe_d = (state_d != StIdle);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            prio_q  <= 1'b0;
            sdrd_q  <= 1'b1;
            sd_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            prio_q  <= prio_d;
            sdrd_q  <= sdrd_d;
            sd_oe_q <= sd_oe_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign sdrd  = sdrd_q;
    assign sd_oe = sd_oe_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_serial_channel_arbiter.sv
// Directed bench for serial_channel_arbiter: default config plus odd parity,
// no parity and a short 5-bit / 2-cycle configuration.
module tb_serial_channel_arbiter;

    logic clk;
    logic rst;

    logic [1:0]  a_valid, a_ready, a_gnt, a_done;
    logic [15:0] a_data;
    logic        a_sdrd, a_oe, a_busy;

    logic [1:0]  b_valid, b_ready, b_gnt, b_done;
    logic [15:0] b_data;
    logic        b_sdrd, b_oe, b_busy;

    logic [1:0]  c_valid, c_ready, c_gnt, c_done;
    logic [15:0] c_data;
    logic        c_sdrd, c_oe, c_busy;

    logic [1:0]  d_valid, d_ready, d_gnt, d_done;
    logic [9:0]  d_data;
    logic        d_sdrd, d_oe, d_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] t1_bits;
    logic [7:0]  t6_bits;

    serial_channel_arbiter u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
        .gnt(a_gnt), .sdrd(a_sdrd), .sd_oe(a_oe), .done(a_done), .busy(a_busy)
    );

    serial_channel_arbiter #(.ODD_PARITY(1)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .gnt(b_gnt), .sdrd(b_sdrd), .sd_oe(b_oe), .done(b_done), .busy(b_busy)
    );

    serial_channel_arbiter #(.PARITY_EN(0)) u_dut_c (
        .clk(clk), .rst(rst), .req_valid(c_valid), .req_data(c_data), .req_ready(c_ready),
        .gnt(c_gnt), .sdrd(c_sdrd), .sd_oe(c_oe), .done(c_done), .busy(c_busy)
    );

    serial_channel_arbiter #(.DATA_W(5), .BIT_CYCLES(2)) u_dut_d (
        .clk(clk), .rst(rst), .req_valid(d_valid), .req_data(d_data), .req_ready(d_ready),
        .gnt(d_gnt), .sdrd(d_sdrd), .sd_oe(d_oe), .done(d_done), .busy(d_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = '0; a_data = '0;
        b_valid = '0; b_data = '0;
        c_valid = '0; c_data = '0;
        d_valid = '0; d_data = '0;
        repeat (3) @(negedge clk);
        check("rst_sdrd",  32'(a_sdrd),  32'd1);
        check("rst_oe",    32'(a_oe),    32'd0);
        check("rst_gnt",   32'(a_gnt),   32'd0);
        check("rst_done",  32'(a_done),  32'd0);
        check("rst_busy",  32'(a_busy),  32'd0);
        check("rst_ready", 32'(a_ready), 32'd0);
        rst = 1'b0;

        // Single frame 0xA5 from requester 0; later inputs change mid-frame and must be ignored.
        t1_bits = 11'b10101001010;
        @(negedge clk);
        a_valid = 2'b01;
        a_data  = 16'h00A5;
        #1;
        check("t1_ready_c0", 32'(a_ready), 32'd1);
        check("t1_gnt_c0",   32'(a_gnt),   32'd0);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 9) a_valid = 2'b00;
            if (c == 10) begin
                a_data  = 16'hFF5A;
                a_valid = 2'b10;
            end
            if (c == 40) a_valid = 2'b00;
            #1;
            check($sformatf("t1_sdrd@%0d", c), 32'(a_sdrd),
                  (c <= 44) ? 32'(t1_bits[(c-1)/4]) : 32'd1);
            check($sformatf("t1_ready@%0d", c), 32'(a_ready), 32'd0);
            check($sformatf("t1_gnt@%0d", c),   32'(a_gnt),  (c <= 44) ? 32'd1 : 32'd0);
            check($sformatf("t1_oe@%0d", c),    32'(a_oe),   (c <= 44) ? 32'd1 : 32'd0);
            check($sformatf("t1_busy@%0d", c),  32'(a_busy), (c <= 44) ? 32'd1 : 32'd0);
            check($sformatf("t1_done@%0d", c),  32'(a_done), (c == 45) ? 32'd1 : 32'd0);
        end

        // Reset in the middle of a frame; pointer would otherwise favour requester 1.
        @(negedge clk);
        a_valid = 2'b01;
        a_data  = 16'h0033;
        #1;
        check("t4_ready_c0", 32'(a_ready), 32'd1);
        repeat (19) @(negedge clk);
        @(negedge clk);
        check("t4_busy_pre", 32'(a_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t4_sdrd", 32'(a_sdrd), 32'd1);
        check("t4_oe",   32'(a_oe),   32'd0);
        check("t4_gnt",  32'(a_gnt),  32'd0);
        check("t4_busy", 32'(a_busy), 32'd0);
        check("t4_done", 32'(a_done), 32'd0);
        @(negedge clk);
        check("t4_done_hold", 32'(a_done), 32'd0);
        rst     = 1'b0;
        a_valid = 2'b11;
        a_data  = {8'h02, 8'h01};
        #1;
        check("t4_first_after_rst", 32'(a_ready), 32'd1);

        // Both requesters continuously valid: grants alternate, no dead cycle.
        for (int c = 1; c <= 180; c++) begin
            @(negedge clk);
            if (c == 136) a_valid = 2'b00;
            #1;
            if (c == 1 || c == 91)  check($sformatf("t2_gnt@%0d", c), 32'(a_gnt), 32'd1);
            if (c == 46 || c == 136) check($sformatf("t2_gnt@%0d", c), 32'(a_gnt), 32'd2);
            if (c == 44 || c == 89) check($sformatf("t2_done@%0d", c), 32'(a_done), 32'd0);
            if (c == 45 || c == 135) begin
                check($sformatf("t2_done@%0d", c),  32'(a_done),  32'd1);
                check($sformatf("t2_ready@%0d", c), 32'(a_ready), 32'd2);
            end
            if (c == 90) begin
                check("t2_done@90",  32'(a_done),  32'd2);
                check("t2_ready@90", 32'(a_ready), 32'd1);
            end
            if (c == 180) begin
                check("t2_done@180", 32'(a_done), 32'd2);
                check("t2_busy@180", 32'(a_busy), 32'd0);
            end
            if (c == 6)  check("t2_sdrd@6",  32'(a_sdrd), 32'd1);
            if (c == 10) check("t2_sdrd@10", 32'(a_sdrd), 32'd0);
            if (c == 50) check("t2_sdrd@50", 32'(a_sdrd), 32'd0);
            if (c == 55) check("t2_sdrd@55", 32'(a_sdrd), 32'd1);
        end

        // Data 0x00: odd parity drives 1; without parity STOP follows bit 7.
        @(negedge clk);
        b_valid = 2'b01; b_data = 16'h0000;
        c_valid = 2'b01; c_data = 16'h0000;
        #1;
        check("t3_b_ready", 32'(b_ready), 32'd1);
        check("t3_c_ready", 32'(c_ready), 32'd1);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) begin
                b_valid = 2'b00;
                c_valid = 2'b00;
            end
            #1;
            if (c == 36) begin
                check("t3_b_sdrd@36", 32'(b_sdrd), 32'd0);
                check("t3_c_sdrd@36", 32'(c_sdrd), 32'd0);
            end
            if (c >= 37 && c <= 40) begin
                check($sformatf("t3_b_par@%0d", c),  32'(b_sdrd), 32'd1);
                check($sformatf("t3_c_stop@%0d", c), 32'(c_sdrd), 32'd1);
            end
            if (c == 40) begin
                check("t3_c_done@40", 32'(c_done), 32'd0);
                check("t3_c_oe@40",   32'(c_oe),   32'd1);
            end
            if (c == 41) begin
                check("t3_c_done@41", 32'(c_done), 32'd1);
                check("t3_c_busy@41", 32'(c_busy), 32'd0);
                check("t3_c_oe@41",   32'(c_oe),   32'd0);
                check("t3_b_oe@41",   32'(b_oe),   32'd1);
            end
            if (c == 44) check("t3_b_done@44", 32'(b_done), 32'd0);
            if (c == 45) check("t3_b_done@45", 32'(b_done), 32'd1);
        end

        // 5-bit word 0x16 at 2 cycles per bit from requester 1: 16-cycle frame.
        t6_bits = 8'b11101100;
        @(negedge clk);
        d_valid = 2'b10;
        d_data  = {5'h16, 5'h00};
        #1;
        check("t6_ready_c0", 32'(d_ready), 32'd2);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1) d_valid = 2'b00;
            #1;
            check($sformatf("t6_sdrd@%0d", c), 32'(d_sdrd),
                  (c <= 16) ? 32'(t6_bits[(c-1)/2]) : 32'd1);
            check($sformatf("t6_gnt@%0d", c),  32'(d_gnt),  (c <= 16) ? 32'd2 : 32'd0);
            check($sformatf("t6_done@%0d", c), 32'(d_done), (c == 17) ? 32'd2 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
